// File: rtl/regfile_ctrl_pkg.sv
// Shared widths, helpers and write-port record for the register-file writeback path.
package regfile_ctrl_pkg;

  localparam int unsigned RF_DATA_WIDTH = 32;
  localparam int unsigned RF_SIZE       = 32;

  function automatic int unsigned addr_width(input int unsigned size);
    return (size > 1) ? $clog2(size) : 1;
  endfunction

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned RF_AW = addr_width(RF_SIZE);

  typedef struct packed {
    logic                     wen;
    logic [RF_AW-1:0]         addr;
    logic [RF_DATA_WIDTH-1:0] data;
  } rf_wr_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from a rotating pointer, pointer kept here.
module rr_arbiter
  import regfile_ctrl_pkg::*;
#(
  parameter int unsigned N = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_en,
  input  logic [N-1:0] i_req,
  output logic [N-1:0] o_gnt
);

  localparam int unsigned IW = idx_width(N);

  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] gnt_idx;
  logic [IW:0]   cand;
  logic          found;
  logic          grant_ok;

  always_comb begin
    gnt_idx = ptr_q;
    found   = 1'b0;
    cand    = '0;
    // Walk ptr, ptr+1, ... with an explicit modulo so N need not be a power of two.
    for (int unsigned i = 0; i < N; i++) begin
      cand = {1'b0, ptr_q} + (IW+1)'(i);
      if (cand >= (IW+1)'(N)) begin
        cand = cand - (IW+1)'(N);
      end
      if (!found && i_req[cand[IW-1:0]]) begin
        found   = 1'b1;
        gnt_idx = cand[IW-1:0];
      end
    end
  end

  assign grant_ok = i_en && !rst && found;

  always_comb begin
    o_gnt = '0;
    if (grant_ok) begin
      o_gnt[gnt_idx] = 1'b1;
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (grant_ok) begin
      ptr_d = (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates writeback sources onto the single register-file write port and forwards the
// registered write onto both read ports.
module regfile_wb_arbiter
  import regfile_ctrl_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH    = 32,
  parameter  int unsigned REG_FILE_SIZE = 32,
  parameter  int unsigned NUM_REQ       = 3,
  localparam int unsigned AW            = addr_width(REG_FILE_SIZE)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_stall,
  input  logic [NUM_REQ-1:0]            i_req_valid,
  input  logic [NUM_REQ*AW-1:0]         i_req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
  output logic [NUM_REQ-1:0]            o_req_ready,
  output logic                          o_wen,
  output logic [AW-1:0]                 o_waddr,
  output logic [DATA_WIDTH-1:0]         o_wdata,
  input  logic [AW-1:0]                 i_raddr1,
  input  logic [AW-1:0]                 i_raddr2,
  input  logic [DATA_WIDTH-1:0]         i_rf_rdata1,
  input  logic [DATA_WIDTH-1:0]         i_rf_rdata2,
  output logic [DATA_WIDTH-1:0]         o_fwd_rdata1,
  output logic [DATA_WIDTH-1:0]         o_fwd_rdata2
);

  // Same layout as rf_wr_t, sized by this instance's parameters.
  typedef struct packed {
    logic                  wen;
    logic [AW-1:0]         addr;
    logic [DATA_WIDTH-1:0] data;
  } wr_t;

  logic [NUM_REQ-1:0]    gnt;
  logic                  any_gnt;
  logic [AW-1:0]         sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;
  wr_t                   wr_q, wr_d;

  rr_arbiter #(
    .N (NUM_REQ)
  ) u_rr_arbiter (
    .clk   (clk),
    .rst   (rst),
    .i_en  (!i_stall),
    .i_req (i_req_valid),
    .o_gnt (gnt)
  );

  assign o_req_ready = gnt;
  assign any_gnt     = |gnt;

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (gnt[k]) begin
        sel_addr = i_req_addr[k*AW +: AW];
        sel_data = i_req_data[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Writes to register 0 are accepted but never reach the port; address/data hold.
  always_comb begin
    wr_d     = wr_q;
    wr_d.wen = 1'b0;
    if (any_gnt && (sel_addr != '0)) begin
      wr_d.wen  = 1'b1;
      wr_d.addr = sel_addr;
      wr_d.data = sel_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
    end else begin
      wr_q <= wr_d;
    end
  end

  assign o_wen   = wr_q.wen;
  assign o_waddr = wr_q.addr;
  assign o_wdata = wr_q.data;

  always_comb begin
    o_fwd_rdata1 = i_rf_rdata1;
    o_fwd_rdata2 = i_rf_rdata2;
    if (wr_q.wen && (wr_q.addr == i_raddr1) && (i_raddr1 != '0)) begin
      o_fwd_rdata1 = wr_q.data;
    end
    if (wr_q.wen && (wr_q.addr == i_raddr2) && (i_raddr2 != '0)) begin
      o_fwd_rdata2 = wr_q.data;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Vector-table bench for regfile_wb_arbiter with a queue of expected register-file writes.
module tb_regfile_wb_arbiter;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned NR = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             i_stall;
  logic [NR-1:0]    i_req_valid;
  logic [NR*AW-1:0] i_req_addr;
  logic [NR*DW-1:0] i_req_data;
  logic [NR-1:0]    o_req_ready;
  logic             o_wen;
  logic [AW-1:0]    o_waddr;
  logic [DW-1:0]    o_wdata;
  logic [AW-1:0]    i_raddr1, i_raddr2;
  logic [DW-1:0]    i_rf_rdata1, i_rf_rdata2;
  logic [DW-1:0]    o_fwd_rdata1, o_fwd_rdata2;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(
    .DATA_WIDTH    (DW),
    .REG_FILE_SIZE (32),
    .NUM_REQ       (NR)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_stall      (i_stall),
    .i_req_valid  (i_req_valid),
    .i_req_addr   (i_req_addr),
    .i_req_data   (i_req_data),
    .o_req_ready  (o_req_ready),
    .o_wen        (o_wen),
    .o_waddr      (o_waddr),
    .o_wdata      (o_wdata),
    .i_raddr1     (i_raddr1),
    .i_raddr2     (i_raddr2),
    .i_rf_rdata1  (i_rf_rdata1),
    .i_rf_rdata2  (i_rf_rdata2),
    .o_fwd_rdata1 (o_fwd_rdata1),
    .o_fwd_rdata2 (o_fwd_rdata2)
  );

  typedef struct {
    logic             rst;
    logic             stall;
    logic [NR-1:0]    valid;
    logic [NR*AW-1:0] addr;
    logic [NR*DW-1:0] data;
    logic [NR-1:0]    exp_ready;
    logic             chk_fwd;
    logic [AW-1:0]    ra1, ra2;
    logic [DW-1:0]    rf1, rf2;
    logic [DW-1:0]    exp_f1, exp_f2;
  } vec_t;

  typedef struct {
    logic          wen;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_wr_t;

  vec_t    vecs[$];
  exp_wr_t exp_q[$];
  int      checks   = 0;
  int      failures = 0;

  function automatic vec_t mk(input logic r, input logic s, input logic [NR-1:0] v,
                              input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                              input logic [AW-1:0] a2, input logic [DW-1:0] d0,
                              input logic [DW-1:0] d1, input logic [DW-1:0] d2,
                              input logic [NR-1:0] er);
    vec_t t;
    t.rst = r;  t.stall = s;  t.valid = v;
    t.addr = {a2, a1, a0};
    t.data = {d2, d1, d0};
    t.exp_ready = er;
    t.chk_fwd = 1'b0;
    t.ra1 = '0;  t.ra2 = '0;  t.rf1 = '0;  t.rf2 = '0;
    t.exp_f1 = '0;  t.exp_f2 = '0;
    return t;
  endfunction

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle's inputs just after a negedge, check, queue next write, wait for next negedge.
  task automatic apply(input vec_t v, input int idx);
    exp_wr_t e;
    rst         = v.rst;
    i_stall     = v.stall;
    i_req_valid = v.valid;
    i_req_addr  = v.addr;
    i_req_data  = v.data;
    i_raddr1    = v.ra1;
    i_raddr2    = v.ra2;
    i_rf_rdata1 = v.rf1;
    i_rf_rdata2 = v.rf2;
    #1;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_empty: vec %0d got no entry expected one", idx);
    end else begin
      e = exp_q.pop_front();
      check($sformatf("wen[%0d]", idx), DW'(o_wen), DW'(e.wen));
      if (e.wen) begin
        check($sformatf("waddr[%0d]", idx), DW'(o_waddr), DW'(e.addr));
        check($sformatf("wdata[%0d]", idx), o_wdata, e.data);
      end
    end
    check($sformatf("ready[%0d]", idx), DW'(o_req_ready), DW'(v.exp_ready));
    if (v.chk_fwd) begin
      check($sformatf("fwd1[%0d]", idx), o_fwd_rdata1, v.exp_f1);
      check($sformatf("fwd2[%0d]", idx), o_fwd_rdata2, v.exp_f2);
    end
    e.wen  = 1'b0;
    e.addr = '0;
    e.data = '0;
    for (int k = 0; k < NR; k++) begin
      if (v.exp_ready[k] && (v.addr[k*AW +: AW] != '0)) begin
        e.wen  = 1'b1;
        e.addr = v.addr[k*AW +: AW];
        e.data = v.data[k*DW +: DW];
      end
    end
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t expected finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t    t;
    exp_wr_t e0;
    logic    served;

    // Reset with everyone requesting.
    vecs.push_back(mk(1, 0, 3'b111, 1, 2, 3, 32'h100, 32'h200, 32'h300, 3'b000));
    vecs.push_back(mk(1, 0, 3'b111, 1, 2, 3, 32'h100, 32'h200, 32'h300, 3'b000));
    // Round robin, sustained writes.
    vecs.push_back(mk(0, 0, 3'b111, 1, 2, 3, 32'h100, 32'h200, 32'h300, 3'b001));
    vecs.push_back(mk(0, 0, 3'b111, 1, 2, 3, 32'h100, 32'h200, 32'h300, 3'b010));
    t = mk(0, 0, 3'b111, 1, 2, 3, 32'h100, 32'h200, 32'h300, 3'b100);
    t.chk_fwd = 1'b1;  t.ra1 = 5'd2;  t.ra2 = 5'd3;  t.rf1 = 32'h11;  t.rf2 = 32'h22;
    t.exp_f1 = 32'h200;  t.exp_f2 = 32'h22;
    vecs.push_back(t);
    vecs.push_back(mk(0, 0, 3'b111, 1, 2, 3, 32'h100, 32'h200, 32'h300, 3'b001));
    vecs.push_back(mk(0, 0, 3'b111, 1, 2, 3, 32'h100, 32'h200, 32'h300, 3'b010));
    vecs.push_back(mk(0, 0, 3'b111, 1, 2, 3, 32'h100, 32'h200, 32'h300, 3'b100));
    // Register-0 drop.
    vecs.push_back(mk(0, 0, 3'b010, 0, 0, 0, 32'h0, 32'hDEADBEEF, 32'h0, 3'b010));
    t = mk(0, 0, 3'b000, 0, 0, 0, 32'h0, 32'h0, 32'h0, 3'b000);
    t.chk_fwd = 1'b1;
    vecs.push_back(t);
    // Stall with requester 2 waiting, then served on release.
    for (int s = 0; s < 3; s++) begin
      vecs.push_back(mk(0, 1, 3'b100, 0, 0, 7, 32'h0, 32'h0, 32'h777, 3'b000));
    end
    vecs.push_back(mk(0, 0, 3'b100, 0, 0, 7, 32'h0, 32'h0, 32'h777, 3'b100));
    // Forwarding of reg 5, then raw pass-through.
    vecs.push_back(mk(0, 0, 3'b001, 5, 0, 0, 32'h1234, 32'h0, 32'h0, 3'b001));
    t = mk(0, 0, 3'b000, 0, 0, 0, 32'h0, 32'h0, 32'h0, 3'b000);
    t.chk_fwd = 1'b1;  t.ra1 = 5'd5;  t.ra2 = 5'd5;  t.exp_f1 = 32'h1234;  t.exp_f2 = 32'h1234;
    vecs.push_back(t);
    t.rf1 = 32'hAAAA;  t.rf2 = 32'h5555;  t.exp_f1 = 32'hAAAA;  t.exp_f2 = 32'h5555;
    vecs.push_back(t);
    // Pointer wrap from 2 to 0, then reset mid-sequence clears the pointer.
    vecs.push_back(mk(0, 0, 3'b010, 0, 4, 0, 32'h0, 32'h44, 32'h0, 3'b010));
    vecs.push_back(mk(0, 0, 3'b011, 8, 9, 0, 32'h88, 32'h99, 32'h0, 3'b001));
    vecs.push_back(mk(0, 0, 3'b010, 8, 9, 0, 32'h88, 32'h99, 32'h0, 3'b010));
    vecs.push_back(mk(1, 0, 3'b011, 8, 9, 0, 32'h88, 32'h99, 32'h0, 3'b000));
    vecs.push_back(mk(0, 0, 3'b110, 0, 9, 10, 32'h0, 32'h99, 32'hAA, 3'b010));
    vecs.push_back(mk(0, 0, 3'b100, 0, 9, 10, 32'h0, 32'h99, 32'hAA, 3'b100));
    vecs.push_back(mk(0, 0, 3'b000, 0, 0, 0, 32'h0, 32'h0, 32'h0, 3'b000));

    rst = 1'b1;  i_stall = 1'b0;  i_req_valid = '0;  i_req_addr = '0;  i_req_data = '0;
    i_raddr1 = '0;  i_raddr2 = '0;  i_rf_rdata1 = '0;  i_rf_rdata2 = '0;
    @(negedge clk);
    check("reset_waddr", DW'(o_waddr), '0);
    check("reset_wdata", o_wdata, '0);
    e0.wen = 1'b0;  e0.addr = '0;  e0.data = '0;
    exp_q.push_back(e0);

    foreach (vecs[i]) apply(vecs[i], i);

    #1;
    e0 = exp_q.pop_front();
    check("final_wen", DW'(o_wen), DW'(e0.wen));

    // Fairness: requester 2 competing with 0 and 1 after a stall, bounded wait.
    i_req_valid = 3'b111;
    i_req_addr  = {5'd3, 5'd2, 5'd1};
    i_stall     = 1'b1;
    @(negedge clk);
    for (int c = 0; c < 2; c++) begin
      #1;
      check("stall_ready", DW'(o_req_ready), '0);
      @(negedge clk);
    end
    i_stall = 1'b0;
    served  = 1'b0;
    for (int c = 0; c < NR; c++) begin
      #1;
      if (o_req_ready[2]) served = 1'b1;
      @(negedge clk);
      if (served) break;
    end
    check("fair_req2", DW'(served), DW'(1'b1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
